// File: rtl/pipe_wb_rf.sv
// pipe_wb_rf: writeback stage with load alignment, register file, bypassed reads and retire counter.
module pipe_wb_rf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mw_valid,
  input  logic              mw_wreg,
  input  logic              mw_m2reg,
  input  logic [REG_AW-1:0] mw_rd,
  input  logic [DATA_W-1:0] mw_alu,
  input  logic [DATA_W-1:0] mw_mem,
  input  logic [2:0]        mw_ldtype,
  input  logic              wb_stall,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_misalign,
  output logic [CNT_W-1:0]  wb_retired
);
  localparam int LW = $clog2(DATA_W / 8);
  localparam int NR = 1 << REG_AW;
  logic [LW-1:0] idx, hidx;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [DATA_W-1:0] ld_val, data_d, data_q;
  logic mis_d, mis_q, valid_q, wreg_q, rd_zero;
  logic [REG_AW-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] rf_q [NR];
  assign idx = mw_alu[LW-1:0];
  assign hidx = {idx[LW-1:1], 1'b0};
  assign lb = mw_mem[{idx, 3'b000} +: 8];
  assign lh = mw_mem[{hidx, 3'b000} +: 16];
  always_comb begin
    ld_val = (mw_ldtype == 3'd1) ? {{(DATA_W-8){lb[7]}}, lb} :
             (mw_ldtype == 3'd2) ? {{(DATA_W-8){1'b0}}, lb} :
             (mw_ldtype == 3'd3) ? {{(DATA_W-16){lh[15]}}, lh} :
             (mw_ldtype == 3'd4) ? {{(DATA_W-16){1'b0}}, lh} : mw_mem;
    data_d = mw_m2reg ? ld_val : mw_alu;
    mis_d = mw_m2reg & ((mw_ldtype == 3'd3) | (mw_ldtype == 3'd4)) & idx[0];
  end
  assign rd_zero = (ZERO_REG != 0) && (rd_q == '0);
  assign wb_we = valid_q & wreg_q & ~mis_q & ~wb_stall & ~rd_zero;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      wreg_q <= 1'b0;
      mis_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < NR; i++) rf_q[i] <= '0;
    end else begin
      if (!wb_stall) begin
        valid_q <= mw_valid;
        wreg_q <= mw_wreg;
        mis_q <= mis_d;
        rd_q <= mw_rd;
        data_q <= data_d;
      end
      if (wb_we) rf_q[rd_q] <= data_q;
      if (valid_q && !wb_stall) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  // Register 0 wins over the bypass so a write aimed at r0 never leaks to decode.
  assign rd1 = ((ZERO_REG != 0) && ra1 == '0) ? '0 : (wb_we && ra1 == rd_q) ? data_q : rf_q[ra1];
  assign rd2 = ((ZERO_REG != 0) && ra2 == '0) ? '0 : (wb_we && ra2 == rd_q) ? data_q : rf_q[ra2];
  assign wb_valid = valid_q;
  assign wb_rd = rd_q;
  assign wb_data = data_q;
  assign wb_misalign = mis_q;
  assign wb_retired = cnt_q;
endmodule

// File: tb/tb_pipe_wb_rf.sv
// tb_pipe_wb_rf: scoreboard bench for pipe_wb_rf with a byte-lane reference model and directed cases.
module tb_pipe_wb_rf;
  logic clk = 1'b0, rst = 1'b1;
  logic mw_valid = 0, mw_wreg = 0, mw_m2reg = 0, wb_stall = 0;
  logic [4:0] mw_rd = 0, ra1 = 0, ra2 = 0, wb_rd;
  logic [31:0] mw_alu = 0, mw_mem = 0, rd1, rd2, wb_data;
  logic [2:0] mw_ldtype = 0;
  logic wb_valid, wb_we, wb_misalign;
  logic [3:0] wb_retired;
  int vec = 0, err = 0;

  typedef struct {
    logic [4:0] rd;
    logic [31:0] data;
    logic mis;
    logic webase;
  } ent_t;
  ent_t q[$];
  logic [31:0] mrf [32];
  logic [3:0] mcnt;

  pipe_wb_rf #(.DATA_W(32), .REG_AW(5), .ZERO_REG(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .mw_valid(mw_valid), .mw_wreg(mw_wreg), .mw_m2reg(mw_m2reg),
    .mw_rd(mw_rd), .mw_alu(mw_alu), .mw_mem(mw_mem), .mw_ldtype(mw_ldtype),
    .wb_stall(wb_stall), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_misalign(wb_misalign), .wb_retired(wb_retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] mem, input logic [31:0] alu, input logic [2:0] t);
    int k = int'(alu % 4);
    int h = k - (k % 2);
    logic [31:0] b = (mem >> (8 * k)) & 32'hFF;
    logic [31:0] w = (mem >> (8 * h)) & 32'hFFFF;
    case (t)
      3'd1: return (b >= 128) ? b - 32'd256 : b;
      3'd2: return b;
      3'd3: return (w >= 32768) ? w - 32'd65536 : w;
      3'd4: return w;
      default: return mem;
    endcase
  endfunction

  // Capture side: each payload accepted by the stage becomes one expected retirement.
  always @(posedge clk) begin
    ent_t e;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 32; i++) mrf[i] = 0;
      mcnt = 0;
    end else if (!wb_stall && mw_valid) begin
      e.rd = mw_rd;
      e.data = mw_m2reg ? align(mw_mem, mw_alu, mw_ldtype) : mw_alu;
      e.mis = mw_m2reg && (mw_ldtype == 3'd3 || mw_ldtype == 3'd4) && (mw_alu % 2 == 1);
      e.webase = mw_wreg && !e.mis && mw_rd != 0;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    ent_t e;
    logic ev, xwe;
    logic [31:0] x1, x2;
    if (!rst) begin
      ev = q.size() > 0;
      xwe = 1'b0;
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, ev});
      if (ev) begin
        e = q[0];
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        chk("wb_data", wb_data, e.data);
        chk("wb_misalign", {31'b0, wb_misalign}, {31'b0, e.mis});
        xwe = e.webase && !wb_stall;
      end
      chk("wb_we", {31'b0, wb_we}, {31'b0, xwe});
      x1 = (ra1 == 0) ? 0 : (xwe && ra1 == e.rd) ? e.data : mrf[ra1];
      x2 = (ra2 == 0) ? 0 : (xwe && ra2 == e.rd) ? e.data : mrf[ra2];
      chk("rd1", rd1, x1);
      chk("rd2", rd2, x2);
      chk("wb_retired", {28'b0, wb_retired}, {28'b0, mcnt});
      if (ev && !wb_stall) begin
        if (xwe) mrf[e.rd] = e.data;
        mcnt = mcnt + 4'd1;
        void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, w, m, input logic [4:0] rdd, input logic [31:0] alu, mem,
                       input logic [2:0] ld, input logic st, input logic [4:0] a1, a2);
    @(posedge clk);
    #1;
    mw_valid = v; mw_wreg = w; mw_m2reg = m; mw_rd = rdd; mw_alu = alu; mw_mem = mem;
    mw_ldtype = ld; wb_stall = st; ra1 = a1; ra2 = a2;
  endtask

  task automatic idle(input logic st, input logic [4:0] a1, a2);
    drive(0, 0, 0, 0, 0, 0, 0, st, a1, a2);
  endtask

  logic [2:0] ldt [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] lda [4] = '{32'd3, 32'd1, 32'd2, 32'd0};
  logic [31:0] ldx [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01};

  initial begin
    logic [4:0] last_rd = 0;
    logic m;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst wb_valid", {31'b0, wb_valid}, 0);
    chk("rst wb_we", {31'b0, wb_we}, 0);
    chk("rst wb_rd", {27'b0, wb_rd}, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst wb_misalign", {31'b0, wb_misalign}, 0);
    chk("rst wb_retired", {28'b0, wb_retired}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // ALU write with bypass then file read
    drive(1, 1, 0, 7, 32'h12345678, 0, 0, 0, 0, 0);
    idle(0, 7, 7);
    @(negedge clk);
    chk("bypass rd1", rd1, 32'h12345678);
    chk("bypass we", {31'b0, wb_we}, 1);
    idle(0, 7, 0);
    @(negedge clk);
    chk("file rd1", rd1, 32'h12345678);
    chk("retired 1", {28'b0, wb_retired}, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 5'(10 + i), lda[i], 32'h80FF7F01, ldt[i], 0, 0, 0);
      idle(0, 0, 0);
      @(negedge clk);
      chk("load data", wb_data, ldx[i]);
    end
    drive(1, 1, 0, 5, 32'hA, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 5, 32'd1, 32'h80FF7F01, 3'd3, 0, 0, 0);
    idle(0, 0, 0);
    @(negedge clk);
    chk("misalign flag", {31'b0, wb_misalign}, 1);
    chk("misalign we", {31'b0, wb_we}, 0);
    idle(0, 5, 5);
    @(negedge clk);
    chk("misalign r5", rd1, 32'hA);
    drive(1, 1, 0, 3, 32'h55, 0, 0, 0, 0, 0);
    repeat (3) begin
      idle(1, 3, 3);
      @(negedge clk);
      chk("stall we", {31'b0, wb_we}, 0);
      chk("stall rd1", rd1, 0);
    end
    idle(0, 3, 3);
    @(negedge clk);
    chk("release we", {31'b0, wb_we}, 1);
    chk("release rd1", rd1, 32'h55);
    drive(1, 1, 0, 0, 32'hDEAD, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    @(negedge clk);
    chk("r0 we", {31'b0, wb_we}, 0);
    chk("r0 rd1", rd1, 0);
    idle(0, 0, 0);
    @(negedge clk);
    chk("retired 9", {28'b0, wb_retired}, 9);
    repeat (6) drive(1, 0, 0, 5'($urandom_range(1, 31)), $urandom, 0, 0, 0, 0, 0);
    repeat (2) idle(0, 0, 0);
    @(negedge clk);
    chk("retired 15", {28'b0, wb_retired}, 15);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) idle(0, 0, 0);
    @(negedge clk);
    chk("retired wrap", {28'b0, wb_retired}, 0);
    // Reset while a write is held by stall
    drive(1, 1, 0, 9, 32'h99, 0, 0, 0, 0, 0);
    idle(1, 9, 9);
    idle(1, 9, 9);
    rst = 1'b1;
    idle(0, 9, 9);
    rst = 1'b0;
    @(negedge clk);
    chk("rst-stall rd1", rd1, 0);
    chk("rst-stall valid", {31'b0, wb_valid}, 0);
    chk("rst-stall retired", {28'b0, wb_retired}, 0);
    for (int i = 0; i < 32; i++) idle(0, 5'(i), 5'(31 - i));
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] rdd, a1, a2;
      m = 1'($urandom_range(0, 1));
      rdd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a1 = ($urandom_range(0, 1) == 0) ? last_rd : 5'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? last_rd : 5'($urandom);
      drive($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), m, rdd, $urandom, $urandom,
            m ? 3'($urandom_range(0, 7)) : 3'd0, $urandom_range(0, 3) == 0, a1, a2);
      last_rd = rdd;
    end
    repeat (3) idle(0, 0, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/pipe_wb_rf.md
# pipe_wb_rf

Parametrised writeback stage for the 5-stage pipeline. It merges the stage register, load-data alignment, the register file and write-to-read bypassing into one block. It takes the MEM/WB payload, selects and extends load data, and commits results to an internal register file with two combinational read ports for decode. It also adds stall hold, misaligned-load trapping and a retired-instruction counter.

## Interface
Parameters:
- `DATA_W`, 32: datapath width; must be a multiple of 16 and at least 32.
- `REG_AW`, 5: register address width; the file holds 2^REG_AW registers.
- `ZERO_REG`, 1: when 1, register 0 reads 0 and ignores writes.
- `CNT_W`, 32: width of the retire counter.

Ports (reset is synchronous, active-high; all state changes on the rising edge of `clk`):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `mw_valid` in 1: MEM/WB payload valid.
- `mw_wreg` in 1: instruction writes a register.
- `mw_m2reg` in 1: result comes from memory (1) or ALU (0).
- `mw_rd` in REG_AW: destination register.
- `mw_alu` in DATA_W: ALU result. Its low bits give the byte address for loads.
- `mw_mem` in DATA_W: raw memory read word.
- `mw_ldtype` in 3: load type. 000 LW (full word), 001 LB, 010 LBU, 011 LH, 100 LHU. Other codes are treated as LW.
- `wb_stall` in 1: hold the stage register.
- `ra1`, `ra2` in REG_AW each: read addresses.
- `rd1`, `rd2` out DATA_W each: read data (combinational).
- `wb_valid` out 1: stage register holds a valid instruction.
- `wb_we` out 1: register write will occur this cycle.
- `wb_rd` out REG_AW: destination register in WB.
- `wb_data` out DATA_W: aligned writeback value.
- `wb_misalign` out 1: WB instruction is a misaligned halfword load.
- `wb_retired` out CNT_W: count of retired instructions.

## Operation
- **Stage register.** Captures `mw_*` when `wb_stall` = 0. When `wb_stall` = 1 it holds all contents.
- **Load alignment.**
  - The memory word is split into byte lanes numbered little-endian; lane k is bits [8k+7:8k].
  - The lane index is the low `log2(DATA_W/8)` bits of `mw_alu`.
  - LB/LBU select that lane and sign- or zero-extend it to DATA_W.
  - LH/LHU select the lane pair starting at the index with bit 0 cleared, then sign- or zero-extend.
  - LW passes `mw_mem` through unchanged.
- **Alignment timing.** Alignment is computed at capture time and stored in the stage register.
- **Result select.** `wb_data` is the aligned load value when `m2reg` = 1, otherwise the ALU result.
- **Misaligned halfword.** LH/LHU with index bit 0 = 1 sets `wb_misalign` = 1 and forces `wb_we` = 0. The instruction still counts as retired.
- **Write enable.** `wb_we` = `wb_valid` & `wreg` & !`wb_misalign` & !`wb_stall` & !(ZERO_REG & `wb_rd` == 0).
- **Register write.** When `wb_we` = 1, the register file is written with `wb_data` at `wb_rd` on the next edge.
- **Read ports.**
  - Reading address 0 with ZERO_REG = 1 returns 0.
  - Otherwise, if `wb_we` = 1 and `ra` == `wb_rd`, the port returns `wb_data` (bypass).
  - Otherwise it returns the register contents.
- **Retire counter.** Increments by 1 on each edge where `wb_valid` = 1 and `wb_stall` = 0. It wraps modulo 2^CNT_W.

## Timing
- **Reset** (rst = 1 at an edge): `wb_valid` = 0, `wb_rd` = 0, `wb_data` = 0, `wb_misalign` = 0, `wb_retired` = 0, and all registers = 0. `wb_we` is therefore 0.
- **Reset priority.** Reset overrides stall, pending writes and counting in the same cycle.
- **Latency.** The payload presented at edge N appears on `wb_*` after edge N. The register file updates at edge N+1. A read of that register in cycle N+1 is bypassed; from cycle N+2 it reads from the file.
- **Stall.** While `wb_stall` = 1 there is no write and no count, and `wb_*` are unchanged. The write commits on the first edge with stall = 0. The instruction is written and counted exactly once.
- **Simultaneous reads.** `ra1` == `ra2` == `wb_rd` gives both ports the bypass value.
- **Invalid payload.** `mw_valid` = 0 captured gives `wb_valid` = 0: no write, no count.
- **Reset mid-stall.** A held instruction is discarded without being written.

## Test plan
- **Reset:** assert rst for 2 cycles → all outputs 0; `rd1`/`rd2` = 0 for every address; `wb_retired` = 0.
- **ALU write and bypass:** ALU write of 0x12345678 to r7, with `ra1` = 7 in the WB cycle → `rd1` = 0x12345678 via bypass, and again in the following cycle from the file; `wb_retired` = 1.
- **Load extraction:** `mw_mem` = 0x80FF7F01 →
  - LB at addr 3 → 0xFFFFFF80
  - LBU at addr 1 → 0x0000007F
  - LH at addr 2 → 0xFFFF80FF
  - LHU at addr 0 → 0x00007F01
- **Misaligned load:** LH at addr 1 targeting r5 (r5 previously 0xA) → `wb_misalign` = 1, `wb_we` = 0, r5 stays 0xA, counter increments.
- **Stall hold:** write r3 = 0x55 held by 3 stall cycles → no write and counter unchanged during stall; exactly one write and +1 count after release.
- **Register 0 and wrap:** write 0xDEAD to r0 → `rd1` with `ra1` = 0 reads 0. Counter preloaded to all-ones via 2^CNT_W − 1 retirements (CNT_W = 4 build) → wraps to 0.
